// File: rtl/spi_sram_responder_if.sv
// SPI pin bundle between a mode-0 SPI master and the serial-SRAM responder.
// Latency: none, plain wires.
// Backpressure: none, SPI has no flow control; the master owns the bit rate.
// Signals:
//   spi_cs_n    chip select, active low (master -> responder)
//   spi_sclk    serial clock, idle low (master -> responder)
//   spi_mosi    serial data, MSB first (master -> responder)
//   spi_miso    serial data, MSB first (responder -> master)
//   spi_miso_oe 1 while the responder drives miso (responder -> master)
interface spi_sram_responder_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_cs_n,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_cs_n,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a small byte-addressed serial SRAM (READ 0x03 / WRITE 0x02).
// Latency: pin edges are acted on 3 clk after they toggle; miso updates on the clk after that.
// Backpressure: none; the SPI master must keep f_sclk <= f_clk/8 so every edge is seen.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   spi           SPI pins (slave modport): cs_n/sclk/mosi in, miso/miso_oe out
//   busy          1 while a transaction is in progress (state != IDLE)
//   bd_addr       backdoor read address
//   bd_rdata      mem[bd_addr], combinational, no side effects
module spi_sram_responder #(
  parameter int MEM_BYTES  = 64,
  parameter int ADDR_W     = $clog2(MEM_BYTES),
  parameter int ADDR_BYTES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_sram_responder_if.slave   spi,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     bd_addr,
  output logic [7:0]            bd_rdata
);

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int         BC_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_ADDR_BYTE = BC_W'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers. These are deliberately not reset: the cs_n pipeline must
  // keep tracking the real pin through rst so that a cs_n held low across rst
  // does not look like a fresh falling edge afterwards.
  // ---------------------------------------------------------------------------
  logic cs_s1, cs_s2;
  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;

  always_ff @(posedge clk) begin
    cs_s1   <= spi.spi_cs_n;
    cs_s2   <= cs_s1;
    sclk_s1 <= spi.spi_sclk;
    sclk_s2 <= sclk_s1;
    sclk_d  <= sclk_s2;
    mosi_s1 <= spi.spi_mosi;
    mosi_s2 <= mosi_s1;
  end

  // cs_d resets to 0 ("already low"), so only a genuine high->low transition
  // after rst can start a transaction.
  logic cs_d;
  always_ff @(posedge clk) begin
    if (rst) cs_d <= 1'b0;
    else     cs_d <= cs_s2;
  end

  logic cs_fall, cs_high, sclk_rise, sclk_fall;
  assign cs_fall   = cs_d & ~cs_s2;
  assign cs_high   = cs_s2;
  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;

  // ---------------------------------------------------------------------------
  // Storage. Not reset; written only on whole-byte completion in WRITE.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:MEM_BYTES-1];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic              is_read_q, is_read_d;
  logic              tx_fresh_q, tx_fresh_d;
  logic              miso_q, miso_d;
  logic              mem_we;

  // Byte as it will look once the current mosi bit is shifted in.
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] rx_addr;
  assign rx_byte = {rx_sr_q[6:0], mosi_s2};
  // ADDR_W <= 8, so only the last address byte survives in the address
  // register; its upper bits are ignored.
  assign rx_addr = rx_byte[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      rx_sr_q    <= 8'h00;
      tx_sr_q    <= 8'h00;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      is_read_q  <= 1'b0;
      tx_fresh_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      is_read_q  <= is_read_d;
      tx_fresh_q <= tx_fresh_d;
      miso_q     <= miso_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr_q] <= rx_byte;
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    is_read_d  = is_read_q;
    tx_fresh_d = tx_fresh_q;
    miso_d     = miso_q;
    mem_we     = 1'b0;

    if (state_q == IDLE) begin
      bit_cnt_d = 3'd0;
      if (cs_fall) state_d = CMD;
    end else if (cs_high) begin
      // Deselect wins over any sclk edge on the same clk; a partial byte is
      // simply dropped.
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      rx_sr_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          CMD: begin
            if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
              state_d    = ADDR;
              byte_cnt_d = '0;
              is_read_d  = (rx_byte == CMD_READ);
            end else begin
              state_d = IGNORE;
            end
          end
          ADDR: begin
            addr_d     = rx_addr;
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            if (byte_cnt_q == LAST_ADDR_BYTE) begin
              if (is_read_q) begin
                // Prefetch the first data byte so miso is ready on the
                // very next sclk fall.
                state_d    = READ;
                tx_sr_d    = mem[rx_addr];
                addr_d     = rx_addr + ADDR_W'(1);
                tx_fresh_d = 1'b1;
              end else begin
                state_d = WRITE;
              end
            end
          end
          READ: begin
            tx_sr_d    = mem[addr_q];
            addr_d     = addr_q + ADDR_W'(1);
            tx_fresh_d = 1'b1;
          end
          WRITE: begin
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end else if (sclk_fall && state_q == READ) begin
      // The first fall after a (re)load presents bit 7 as-is; later falls
      // shift and present the next bit, giving exactly 8 bits per byte.
      if (tx_fresh_q) begin
        miso_d     = tx_sr_q[7];
        tx_fresh_d = 1'b0;
      end else begin
        tx_sr_d = {tx_sr_q[6:0], 1'b0};
        miso_d  = tx_sr_q[6];
      end
    end

    // miso is parked low whenever the responder is not driving it.
    if (state_d != READ) miso_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = (state_q == READ);
  assign busy            = (state_q != IDLE);
  assign bd_rdata        = mem[bd_addr];

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: bit-bangs SPI mode-0 transactions and checks
// memory via the backdoor port, miso data, oe and busy against hand-computed values.
// sclk half period is 8 clk; miso/oe are sampled just before each sclk rise.
module tb_spi_sram_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [5:0] bd_addr;
  logic [7:0] bd_rdata;

  always #5 clk = ~clk;

  spi_sram_responder_if spi_if ();

  spi_sram_responder #(
    .MEM_BYTES (64),
    .ADDR_W    (6),
    .ADDR_BYTES(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .spi     (spi_if.slave),
    .busy    (busy),
    .bd_addr (bd_addr),
    .bd_rdata(bd_rdata)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] rx;
  logic       oe_any;
  logic       oe_all;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    spi_if.spi_mosi = b;
    tick(8);
    rx     = {rx[6:0], spi_if.spi_miso};
    oe_any = oe_any | spi_if.spi_miso_oe;
    oe_all = oe_all & spi_if.spi_miso_oe;
    spi_if.spi_sclk = 1'b1;
    tick(8);
    spi_if.spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_start();
    spi_if.spi_cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_stop();
    tick(8);
    spi_if.spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] addr);
    spi_byte(cmd);
    spi_byte(8'h00);
    spi_byte(8'h00);
    spi_byte(addr);
  endtask

  task automatic bd_check(input string tag, input logic [5:0] a, input logic [7:0] exp);
    bd_addr = a;
    #1;
    check(tag, {24'h0, bd_rdata}, {24'h0, exp});
  endtask

  initial begin
    spi_if.spi_cs_n = 1'b1;
    spi_if.spi_sclk = 1'b0;
    spi_if.spi_mosi = 1'b0;
    bd_addr = '0;
    rx      = '0;
    oe_any  = 1'b0;
    oe_all  = 1'b1;
    rst     = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_oe", {31'h0, spi_if.spi_miso_oe}, 32'h0);
    check("rst_miso", {31'h0, spi_if.spi_miso}, 32'h0);

    // 1: WRITE A5 to address 5, busy drops within 4 clk of cs high
    cs_start();
    send_hdr(8'h02, 8'h05);
    spi_byte(8'hA5);
    tick(8);
    check("t1_busy_active", {31'h0, busy}, 32'h1);
    spi_if.spi_cs_n = 1'b1;
    tick(4);
    check("t1_busy_idle", {31'h0, busy}, 32'h0);
    tick(4);
    bd_check("t1_mem5", 6'h05, 8'hA5);

    // 2: READ address 5, oe only in the data phase
    oe_any = 1'b0;
    cs_start();
    send_hdr(8'h03, 8'h05);
    check("t2_oe_hdr", {31'h0, oe_any}, 32'h0);
    oe_all = 1'b1;
    rx     = '0;
    spi_byte(8'h00);
    check("t2_rd_data", {24'h0, rx}, 32'hA5);
    check("t2_oe_data", {31'h0, oe_all}, 32'h1);
    cs_stop();
    check("t2_oe_after", {31'h0, spi_if.spi_miso_oe}, 32'h0);
    check("t2_miso_after", {31'h0, spi_if.spi_miso}, 32'h0);

    // 3: WRITE across the 0x3F -> 0x00 wrap, then read it back
    cs_start();
    send_hdr(8'h02, 8'h3F);
    spi_byte(8'h11);
    spi_byte(8'h22);
    cs_stop();
    bd_check("t3_mem3f", 6'h3F, 8'h11);
    bd_check("t3_mem00", 6'h00, 8'h22);
    cs_start();
    send_hdr(8'h03, 8'h3F);
    rx = '0;
    spi_byte(8'h00);
    check("t3_rd_byte0", {24'h0, rx}, 32'h11);
    rx = '0;
    spi_byte(8'h00);
    check("t3_rd_byte1", {24'h0, rx}, 32'h22);
    cs_stop();

    // 4: unknown command is ignored
    oe_any = 1'b0;
    cs_start();
    spi_byte(8'h9F);
    spi_byte(8'hFF);
    spi_byte(8'hFF);
    check("t4_oe_ignore", {31'h0, oe_any}, 32'h0);
    check("t4_busy_ignore", {31'h0, busy}, 32'h1);
    cs_stop();
    bd_check("t4_mem5", 6'h05, 8'hA5);
    bd_check("t4_mem3f", 6'h3F, 8'h11);
    bd_check("t4_mem00", 6'h00, 8'h22);
    cs_start();
    send_hdr(8'h03, 8'h05);
    rx = '0;
    spi_byte(8'h00);
    check("t4_rd_mem5", {24'h0, rx}, 32'hA5);
    cs_stop();

    // 5: a partial trailing byte is not committed
    cs_start();
    send_hdr(8'h02, 8'h08);
    spi_byte(8'h3C);
    cs_stop();
    bd_check("t5_mem8_pre", 6'h08, 8'h3C);
    cs_start();
    send_hdr(8'h02, 8'h07);
    spi_byte(8'hFF);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    cs_stop();
    bd_check("t5_mem7", 6'h07, 8'hFF);
    bd_check("t5_mem8", 6'h08, 8'h3C);

    // 6: rst in the middle of a READ data phase
    cs_start();
    send_hdr(8'h03, 8'h05);
    rx = '0;
    for (int i = 0; i < 3; i++) spi_bit(1'b0);
    check("t6_first_bits", {29'h0, rx[2:0]}, 32'h5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_oe_rst", {31'h0, spi_if.spi_miso_oe}, 32'h0);
    check("t6_busy_rst", {31'h0, busy}, 32'h0);
    check("t6_miso_rst", {31'h0, spi_if.spi_miso}, 32'h0);
    oe_any = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(1'b0);
    check("t6_oe_held", {31'h0, oe_any}, 32'h0);
    check("t6_busy_held", {31'h0, busy}, 32'h0);
    cs_stop();
    bd_check("t6_mem5", 6'h05, 8'hA5);
    cs_start();
    send_hdr(8'h03, 8'h05);
    rx = '0;
    spi_byte(8'h00);
    check("t6_rd_after", {24'h0, rx}, 32'hA5);
    cs_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
